// File: rtl/program_loader.sv
// Serial program loader: length-prefixed byte stream packed into 32-bit words and written to instruction memory.
// Define PROGRAM_LOADER_CSUM_EN to add a trailing XOR checksum byte and the ERROR path.
module program_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA, WRITE,
`ifdef PROGRAM_LOADER_CSUM_EN
        CSUM,
`endif
        DONE, ERROR
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [15:0]       r_len;
    logic [15:0]       r_wcnt;
    logic [1:0]        r_bcnt;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              w_acc;
    logic              w_start_ok;
    logic              w_more;

    assign w_acc      = byte_valid && byte_ready;
    assign w_start_ok = start && (r_state == IDLE || r_state == DONE || r_state == ERROR);
    assign w_more     = ({1'b0, r_wcnt} + 17'd1) < {1'b0, r_len};

    assign byte_ready = (r_state == LEN_HI) || (r_state == LEN_LO) || (r_state == DATA)
`ifdef PROGRAM_LOADER_CSUM_EN
                        || (r_state == CSUM)
`endif
                        ;
    assign imem_we    = (r_state == WRITE);
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_hold   = (r_state != DONE);
    assign load_done  = (r_state == DONE);

`ifdef PROGRAM_LOADER_CSUM_EN
    logic [7:0] r_csum;
    localparam state_t TAIL = CSUM;
    assign load_err = (r_state == ERROR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          r_csum <= 8'd0;
        else if (w_start_ok)                 r_csum <= 8'd0;
        else if (r_state == DATA && w_acc)   r_csum <= r_csum ^ byte_in;
    end
`else
    localparam state_t TAIL = DONE;
    assign load_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE, DONE, ERROR: if (start) w_state_nxt = LEN_HI;
            LEN_HI:            if (w_acc) w_state_nxt = LEN_LO;
            LEN_LO:            if (w_acc) w_state_nxt = ({r_len[15:8], byte_in} != 16'd0) ? DATA : TAIL;
            DATA:              if (w_acc && r_bcnt == 2'd3) w_state_nxt = WRITE;
            WRITE:             w_state_nxt = w_more ? DATA : TAIL;
`ifdef PROGRAM_LOADER_CSUM_EN
            CSUM:              if (w_acc) w_state_nxt = (byte_in == r_csum) ? DONE : ERROR;
`endif
            default:           w_state_nxt = IDLE;
        endcase
    end

    // Word data shifts in big-endian, so after four bytes the first one sits in [31:24].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len   <= 16'd0;
            r_wcnt  <= 16'd0;
            r_bcnt  <= 2'd0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
        end else if (w_start_ok) begin
            r_len  <= 16'd0;
            r_wcnt <= 16'd0;
            r_bcnt <= 2'd0;
            r_addr <= '0;
        end else begin
            case (r_state)
                LEN_HI: if (w_acc) r_len[15:8] <= byte_in;
                LEN_LO: if (w_acc) r_len[7:0]  <= byte_in;
                DATA: if (w_acc) begin
                    r_wdata <= {r_wdata[23:0], byte_in};
                    r_bcnt  <= r_bcnt + 2'd1;
                end
                WRITE: begin
                    r_addr <= r_addr + 1'b1;
                    r_wcnt <= r_wcnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a default-depth instance and an ADDR_W=2 instance share all inputs.
module tb_program_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;

    logic        rdy_a, we_a, hold_a, done_a, err_a;
    logic [9:0]  addr_a;
    logic [31:0] wd_a;
    logic        rdy_b, we_b, hold_b, done_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] wd_b;

    int n_chk = 0;
    int n_err = 0;

    int          qa_addr[$];
    logic [31:0] qa_data[$];
    int          qb_addr[$];
    logic [31:0] qb_data[$];
    logic [31:0] mem_b[4];

    always #5 clk = ~clk;

    program_loader #(.ADDR_W(10)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(rdy_a), .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wd_a),
        .cpu_hold(hold_a), .load_done(done_a), .load_err(err_a));

    program_loader #(.ADDR_W(2)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(rdy_b), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wd_b),
        .cpu_hold(hold_b), .load_done(done_b), .load_err(err_b));

    always @(negedge clk) begin
        if (we_a) begin qa_addr.push_back(int'(addr_a)); qa_data.push_back(wd_a); end
        if (we_b) begin qb_addr.push_back(int'(addr_b)); qb_data.push_back(wd_b); mem_b[addr_b] = wd_b; end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Returns #1 after the edge that accepted the byte.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        for (int i = 0; i < gap; i++) begin @(negedge clk); byte_valid = 1'b0; end
        @(negedge clk); byte_in = b; byte_valid = 1'b1;
        while (!rdy_a && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) chk("byte_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1 byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[31:24], gap); send_byte(w[23:16], gap);
        send_byte(w[15:8],  gap); send_byte(w[7:0],   gap);
    endtask

    task automatic wait_end(input string tag);
        int t;
        t = 0;
        while (!(done_a || err_a) && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int base;
        // reset state
        #12;
        chk("rst_hold", 32'(hold_a), 32'd1);
        chk("rst_ready", 32'(rdy_a), 32'd0);
        chk("rst_we", 32'(we_a), 32'd0);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_wdata", wd_a, 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start_ready", 32'(rdy_a), 32'd0);

        // single word
        base = qa_addr.size();
        pulse_start();
        chk("t1_ready_lenhi", 32'(rdy_a), 32'd1);
        chk("t1_hold_busy", 32'(hold_a), 32'd1);
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_word(32'h12345678, 0);
`ifdef PROGRAM_LOADER_CSUM_EN
        send_byte(8'h08, 0);
`endif
        wait_end("t1");
        chk("t1_done", 32'(done_a), 32'd1);
        chk("t1_hold_off", 32'(hold_a), 32'd0);
        chk("t1_nwrites", 32'(qa_addr.size() - base), 32'd1);
        chk("t1_addr", 32'(qa_addr[base]), 32'd0);
        chk("t1_data", qa_data[base], 32'h12345678);

        // two words with byte_valid gaps
        base = qa_addr.size();
        pulse_start();
        chk("t2_done_cleared", 32'(done_a), 32'd0);
        send_byte(8'h00, 1); send_byte(8'h02, 1);
        send_word(32'h20080005, 1);
        send_word(32'h2109FFFF, 1);
`ifdef PROGRAM_LOADER_CSUM_EN
        send_byte(8'h05, 1);
`endif
        wait_end("t2");
        chk("t2_done", 32'(done_a), 32'd1);
        chk("t2_nwrites", 32'(qa_addr.size() - base), 32'd2);
        chk("t2_addr0", 32'(qa_addr[base]), 32'd0);
        chk("t2_data0", qa_data[base], 32'h20080005);
        chk("t2_addr1", 32'(qa_addr[base+1]), 32'd1);
        chk("t2_data1", qa_data[base+1], 32'h2109FFFF);

        // zero-length load
        base = qa_addr.size();
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h00, 0);
`ifdef PROGRAM_LOADER_CSUM_EN
        chk("t3_not_yet_done", 32'(done_a), 32'd0);
        send_byte(8'h00, 0);
`endif
        chk("t3_done_now", 32'(done_a), 32'd1);
        chk("t3_nwrites", 32'(qa_addr.size() - base), 32'd0);

`ifdef PROGRAM_LOADER_CSUM_EN
        // checksum match and mismatch
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_word(32'hAABBCCDD, 0);
        send_byte(8'h00, 0);
        chk("t4_good_done", 32'(done_a), 32'd1);
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_word(32'hAABBCCDD, 0);
        send_byte(8'h01, 0);
        chk("t4_bad_err", 32'(err_a), 32'd1);
        chk("t4_bad_done", 32'(done_a), 32'd0);
        chk("t4_bad_hold", 32'(hold_a), 32'd1);
        repeat (3) @(negedge clk);
        chk("t4_err_sticky", 32'(err_a), 32'd1);
        pulse_start();
        chk("t4_recover_ready", 32'(rdy_a), 32'd1);
        chk("t4_recover_err", 32'(err_a), 32'd0);
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        chk("t4_recover_done", 32'(done_a), 32'd1);
`endif

        // reset mid-DATA
        base = qa_addr.size();
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("t5_rst_hold", 32'(hold_a), 32'd1);
        chk("t5_rst_ready", 32'(rdy_a), 32'd0);
        chk("t5_rst_wdata", wd_a, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_idle_ready", 32'(rdy_a), 32'd0);
        chk("t5_no_write", 32'(qa_addr.size() - base), 32'd0);
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_word(32'h11223344, 0);
`ifdef PROGRAM_LOADER_CSUM_EN
        send_byte(8'h44, 0);
`endif
        wait_end("t5");
        chk("t5_nwrites", 32'(qa_addr.size() - base), 32'd1);
        chk("t5_addr", 32'(qa_addr[base]), 32'd0);
        chk("t5_data", qa_data[base], 32'h11223344);

        // five words: wraps on the small instance; stray start mid-DATA
        base = qa_addr.size();
        qb_addr.delete(); qb_data.delete();
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h05, 0);
        send_word(32'hC0DE0000, 0);
        send_byte(8'hC0, 0); send_byte(8'hDE, 0);
        pulse_start();
        chk("t6_start_ignored", 32'(rdy_a), 32'd1);
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        for (int i = 2; i < 5; i++) send_word(32'hC0DE0000 | 32'(i), 0);
`ifdef PROGRAM_LOADER_CSUM_EN
        send_byte(8'h1A, 0);
`endif
        wait_end("t6");
        @(negedge clk);
        chk("t6_done_small", 32'(done_b), 32'd1);
        chk("t6_nwrites_big", 32'(qa_addr.size() - base), 32'd5);
        chk("t6_nwrites_small", 32'(qb_addr.size()), 32'd5);
        if (qb_addr.size() == 5 && qa_addr.size() - base == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("t6_big_addr%0d", i), 32'(qa_addr[base+i]), 32'(i));
                chk($sformatf("t6_small_addr%0d", i), 32'(qb_addr[i]), 32'(i % 4));
                chk($sformatf("t6_small_data%0d", i), qb_data[i], 32'hC0DE0000 | 32'(i));
            end
        end
        chk("t6_mem0_final", mem_b[0], 32'hC0DE0004);
        chk("t6_mem1", mem_b[1], 32'hC0DE0001);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
